// File: rtl/mem_wb_pkg.sv
// Shared types and payload layout helpers for the MEM/WB stage register.
// The state encoding doubles as the occupancy count.
package mem_wb_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_e;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 4;
    localparam int PAYLOAD_W      = 2 + 2*DATA_W_DEF + REG_ADDR_W_DEF;

    // Payload layout, LSB first: dest, mem_read_value, alu_result,
    // mem_r_en, wb_en.
    function automatic int payload_w(input int dw, input int aw);
        return 2 + 2*dw + aw;
    endfunction

    function automatic int mrv_lsb(input int dw, input int aw);
        return aw + 0*dw;
    endfunction

    function automatic int alu_lsb(input int dw, input int aw);
        return aw + dw;
    endfunction

    function automatic int mren_bit(input int dw, input int aw);
        return aw + 2*dw;
    endfunction

    function automatic int wben_bit(input int dw, input int aw);
        return aw + 2*dw + 1;
    endfunction

endpackage

// File: rtl/mem_wb_stage_reg_v2_pipe_skid_ctrl.sv
// Valid/ready control for a one-entry-skid pipeline register.
// Emits load enables for the main and skid payload registers.
module pipe_skid_ctrl
    import mem_wb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flush_i,
    input  logic       in_valid_i,
    input  logic       out_ready_i,
    output logic       in_ready_o,
    output logic       out_valid_o,
    output logic [1:0] occupancy_o,
    output logic       main_load_o,
    output logic       main_sel_skid_o,
    output logic       skid_load_o
);

    state_e state_q, state_d;
    logic   accept;
    logic   consume;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Both derived from the state register only, so no ready combinational path.
    assign in_ready_o  = (state_q != SKID);
    assign out_valid_o = (state_q != EMPTY);
    assign occupancy_o = state_q;

    assign accept  = in_valid_i & in_ready_o;
    assign consume = out_valid_o & out_ready_i;

    always_comb begin
        state_d         = state_q;
        main_load_o     = 1'b0;
        main_sel_skid_o = 1'b0;
        skid_load_o     = 1'b0;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d     = FULL;
                        main_load_o = 1'b1;
                    end
                end
                FULL: begin
                    if (accept && consume) begin
                        main_load_o = 1'b1;
                    end else if (accept) begin
                        state_d     = SKID;
                        skid_load_o = 1'b1;
                    end else if (consume) begin
                        state_d = EMPTY;
                    end
                end
                SKID: begin
                    if (consume) begin
                        state_d         = FULL;
                        main_load_o     = 1'b1;
                        main_sel_skid_o = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/mem_wb_stage_reg_v2.sv
// MEM/WB pipeline register with handshake, skid entry, flush and
// registered write-back mux plus hazard-unit forwarding tap.
module mem_wb_stage_reg_v2
    import mem_wb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_wb_en,
    input  logic                  in_mem_r_en,
    input  logic [DATA_W-1:0]     in_alu_result,
    input  logic [DATA_W-1:0]     in_mem_read_value,
    input  logic [REG_ADDR_W-1:0] in_dest,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_wb_en,
    output logic                  out_mem_r_en,
    output logic [DATA_W-1:0]     out_alu_result,
    output logic [DATA_W-1:0]     out_mem_read_value,
    output logic [REG_ADDR_W-1:0] out_dest,
    output logic [DATA_W-1:0]     out_wb_value,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_dest,
    output logic [DATA_W-1:0]     fwd_value,
    output logic [1:0]            occupancy
);

    localparam int PW   = payload_w(DATA_W, REG_ADDR_W);
    localparam int MRV  = mrv_lsb(DATA_W, REG_ADDR_W);
    localparam int ALU  = alu_lsb(DATA_W, REG_ADDR_W);
    localparam int MREN = mren_bit(DATA_W, REG_ADDR_W);
    localparam int WBEN = wben_bit(DATA_W, REG_ADDR_W);

    logic [PW-1:0] in_pl;
    logic [PW-1:0] main_q, main_d;
    logic [PW-1:0] skid_q, skid_d;
    logic          main_load;
    logic          main_sel_skid;
    logic          skid_load;

    pipe_skid_ctrl u_ctrl (
        .clk             (clk),
        .rst             (rst),
        .flush_i         (flush),
        .in_valid_i      (in_valid),
        .out_ready_i     (out_ready),
        .in_ready_o      (in_ready),
        .out_valid_o     (out_valid),
        .occupancy_o     (occupancy),
        .main_load_o     (main_load),
        .main_sel_skid_o (main_sel_skid),
        .skid_load_o     (skid_load)
    );

    assign in_pl = {in_wb_en, in_mem_r_en, in_alu_result,
                    in_mem_read_value, in_dest};

    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (main_load) begin
            main_d = main_sel_skid ? skid_q : in_pl;
        end
        if (skid_load) begin
            skid_d = in_pl;
        end
    end

    // Payloads are not cleared by flush; only the valid state is.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    assign out_dest           = main_q[REG_ADDR_W-1:0];
    assign out_mem_read_value = main_q[MRV +: DATA_W];
    assign out_alu_result     = main_q[ALU +: DATA_W];
    assign out_mem_r_en       = main_q[MREN];
    assign out_wb_en          = main_q[WBEN] & out_valid;

    assign out_wb_value = out_mem_r_en ? out_mem_read_value
                                       : out_alu_result;

    assign fwd_valid = out_valid & out_wb_en;
    assign fwd_dest  = out_dest;
    assign fwd_value = out_wb_value;

endmodule

// File: tb/tb_mem_wb_stage_reg_v2.sv
// Directed bench for mem_wb_stage_reg_v2.
// Inputs change and outputs are sampled on the falling edge.
module tb_mem_wb_stage_reg_v2;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        in_wb_en;
    logic        in_mem_r_en;
    logic [31:0] in_alu_result;
    logic [31:0] in_mem_read_value;
    logic [3:0]  in_dest;
    logic        out_valid;
    logic        out_ready;
    logic        out_wb_en;
    logic        out_mem_r_en;
    logic [31:0] out_alu_result;
    logic [31:0] out_mem_read_value;
    logic [3:0]  out_dest;
    logic [31:0] out_wb_value;
    logic        fwd_valid;
    logic [3:0]  fwd_dest;
    logic [31:0] fwd_value;
    logic [1:0]  occupancy;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_wb_stage_reg_v2 dut (
        .clk                (clk),
        .rst                (rst),
        .flush              (flush),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_wb_en           (in_wb_en),
        .in_mem_r_en        (in_mem_r_en),
        .in_alu_result      (in_alu_result),
        .in_mem_read_value  (in_mem_read_value),
        .in_dest            (in_dest),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_wb_en          (out_wb_en),
        .out_mem_r_en       (out_mem_r_en),
        .out_alu_result     (out_alu_result),
        .out_mem_read_value (out_mem_read_value),
        .out_dest           (out_dest),
        .out_wb_value       (out_wb_value),
        .fwd_valid          (fwd_valid),
        .fwd_dest           (fwd_dest),
        .fwd_value          (fwd_value),
        .occupancy          (occupancy)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic wb, input logic mr,
                         input logic [31:0] alu, input logic [31:0] mrv,
                         input logic [3:0] d);
        in_valid          = v;
        in_wb_en          = wb;
        in_mem_r_en       = mr;
        in_alu_result     = alu;
        in_mem_read_value = mrv;
        in_dest           = d;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        step();
        chk("rst_valid", out_valid, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_wben", out_wb_en, 0);
        chk("rst_fwdv", fwd_valid, 0);
        chk("rst_wbval", out_wb_value, 0);
        rst = 1'b0;
        step();

        // streaming
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'(i), 32'h55, 4'd5);
            step();
            chk("str_wbval", out_wb_value, 64'(i));
            chk("str_fwdv", fwd_valid, 1);
            chk("str_fwdd", fwd_dest, 5);
            chk("str_fwdval", fwd_value, 64'(i));
            chk("str_occ", occupancy, 1);
        end
        drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 4'd5);
        step();
        chk("str_drain", occupancy, 0);

        // back-pressure
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'hA, 32'h0, 4'd1);
        step();
        chk("bp_a_out", out_alu_result, 32'hA);
        chk("bp_a_occ", occupancy, 1);
        chk("bp_a_rdy", in_ready, 1);
        drive(1'b1, 1'b1, 1'b0, 32'hB, 32'h0, 4'd2);
        step();
        chk("bp_b_occ", occupancy, 2);
        chk("bp_b_rdy", in_ready, 0);
        chk("bp_b_out", out_alu_result, 32'hA);
        drive(1'b1, 1'b1, 1'b0, 32'hC, 32'h0, 4'd3);
        step();
        chk("bp_c_held", out_alu_result, 32'hA);
        chk("bp_c_occ", occupancy, 2);
        out_ready = 1'b1;
        step();
        chk("bp_drain_b", out_alu_result, 32'hB);
        chk("bp_drain_bd", out_dest, 2);
        chk("bp_drain_occ", occupancy, 1);
        step();
        chk("bp_drain_c", out_alu_result, 32'hC);
        chk("bp_drain_cd", out_dest, 3);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        step();
        chk("bp_empty", occupancy, 0);

        // load select
        drive(1'b1, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'd7);
        step();
        chk("ld_sel", out_wb_value, 32'hDEADBEEF);
        chk("ld_flag", out_mem_r_en, 1);
        drive(1'b1, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 4'd7);
        step();
        chk("alu_sel", out_wb_value, 32'h100);

        // bubble
        drive(1'b0, 1'b1, 1'b0, 32'h77, 32'h0, 4'd9);
        step();
        chk("bub_wben", out_wb_en, 0);
        chk("bub_valid", out_valid, 0);

        // flush with skid occupied and an input pending
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'hD1, 32'h0, 4'd1);
        step();
        drive(1'b1, 1'b1, 1'b0, 32'hE1, 32'h0, 4'd2);
        step();
        chk("fl_pre_occ", occupancy, 2);
        drive(1'b1, 1'b1, 1'b0, 32'hF1, 32'h0, 4'd3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_occ", occupancy, 0);
        chk("fl_wben", out_wb_en, 0);
        chk("fl_fwdv", fwd_valid, 0);
        chk("fl_rdy", in_ready, 1);
        chk("fl_stale", out_alu_result, 32'hD1);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        out_ready = 1'b1;
        step();
        chk("fl_dropped", occupancy, 0);
        chk("fl_stale2", out_alu_result, 32'hD1);

        // async reset mid-stream with skid occupied
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 32'h61, 32'h62, 4'd6);
        step();
        drive(1'b1, 1'b1, 1'b0, 32'h71, 32'h72, 4'd7);
        step();
        chk("ar_pre_occ", occupancy, 2);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_occ", occupancy, 0);
        chk("ar_rdy", in_ready, 1);
        chk("ar_wben", out_wb_en, 0);
        chk("ar_wbval", out_wb_value, 0);
        chk("ar_alu", out_alu_result, 0);
        chk("ar_dest", out_dest, 0);
        step();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        step();
        chk("ar_after", occupancy, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
